ulpi_link_ctrl: RTL
===================

// Module: ulpi_link_ctrl
// PURPOSE
//  Link-side ULPI controller: owns bus turnaround and drives stp/data for the link.
//  Sends USB packets as TX CMD + payload, and performs PHY register writes and reads.
//  Splits PHY-driven cycles into RX data bytes and RX CMD bytes.
//  Sits between the ULPI pad wrapper (tri data split into i/o/oe) and the USB protocol engine.
// PARAMETERS
//  TX_FIFO_DEPTH  4    TX byte FIFO entries; power of 2, >=2.
//  REG_TIMEOUT    255  Max cycles waiting for nxt on a register cmd before reg_err.
// PORTS
//  clk          in   1  ULPI 60 MHz clock; all logic on posedge.
//  rst          in   1  Synchronous, active-high reset.
//  ulpi_dir     in   1  PHY bus direction (1 = PHY drives data).
//  ulpi_nxt     in   1  PHY throttle / data-byte strobe.
//  ulpi_stp     out  1  Link stop strobe.
//  ulpi_data_i  in   8  Data from the pad.
//  ulpi_data_o  out  8  Data to the pad.
//  ulpi_data_oe out  1  Pad output enable.
//  tx_data      in   8  Packet byte; first byte of a packet is the PID.
//  tx_valid     in   1  tx_data valid.
//  tx_last      in   1  Marks the last byte of a packet.
//  tx_ready     out  1  FIFO has space (valid/ready handshake).
//  tx_abort     out  1  1-cycle pulse: packet aborted by dir or by FIFO underrun.
//  rx_data      out  8  Received byte.
//  rx_valid     out  1  rx_data strobe.
//  rx_end       out  1  1-cycle pulse on the dir fall that ends an RX which delivered >=1 byte.
//  rxcmd        out  8  Last RX CMD byte; held until the next RX CMD.
//  rxcmd_valid  out  1  1-cycle strobe on each RX CMD.
//  reg_req      in   1  Register access request; held until reg_ack.
//  reg_we       in   1  1 = write, 0 = read.
//  reg_addr     in   6  PHY register address.
//  reg_wdata    in   8  Write data.
//  reg_ack      out  1  1-cycle completion pulse.
//  reg_err      out  1  Valid with reg_ack: timeout occurred.
//  reg_rdata    out  8  Read data; valid with reg_ack.
// BEHAVIOUR
//  Reset values: stp=0, data_o=0x00, data_oe=0, tx_ready=0.
//  Reset values: all strobes/pulses=0, rxcmd=0x00, reg_rdata=0x00.
//  Reset empties the FIFO, drops any pending/in-flight op, and forces state IDLE.
//  Turnaround: dir_q = dir registered. Turnaround cycle = any cycle with dir != dir_q.
//  data_oe = !dir & !dir_q. Data is never sampled or driven in a turnaround cycle.
//  RX (dir & dir_q): nxt=1 -> rx_data/rx_valid; nxt=0 -> rxcmd/rxcmd_valid. Outputs registered, 1-cycle latency.
//  States: IDLE, TX_CMD, TX_DATA, TX_STP, REG_CMD, REG_WD, REG_STP, REG_TURN, REG_RD.
//  IDLE: drives 0x00. When the bus is link-owned: reg_req has priority, else start TX on a FIFO packet head.
//  TX_CMD: drive 0x40|pid[3:0] until nxt=1. Then TX_DATA: drive the next FIFO byte.
//  TX_DATA: pop on each nxt=1 cycle. Once tx_last is accepted: TX_STP (stp=1, data 0x00, one cycle) -> IDLE.
//  Zero-payload packet (PID only): TX_CMD -> TX_STP directly.
//  Underrun: FIFO empty in TX_DATA while nxt=1 -> stp=1 with data 0xFF; pulse tx_abort; flush rest of packet.
//  dir rising in TX_CMD/TX_DATA: release bus, pulse tx_abort, flush FIFO through tx_last, go to IDLE (service RX).
//  Write: REG_CMD drives 0x80|addr until nxt; REG_WD drives wdata until nxt; REG_STP stp=1; then reg_ack.
//  Read: REG_CMD drives 0xC0|addr until nxt; REG_TURN expects dir rise; REG_RD latches data_i.
//  Read completion: reg_rdata valid and reg_ack pulse one cycle after REG_RD.
//  dir rising during REG_CMD/REG_WD, or no dir at REG_TURN: drop the op and keep reg_req pending.
//  The dropped op is re-issued from REG_CMD once IDLE, with no ack.
//  REG_TIMEOUT: counts nxt-wait cycles in REG_CMD/REG_WD. At the limit: reg_ack=1, reg_err=1, go to IDLE.
//  FIFO: tx_ready = !full. Simultaneous push and pop while full is rejected (push is gated by tx_ready).
// STRUCTURE
//  ulpi_pkg:
//   - state_t enum.
//   - TXCMD_NOPID=8'h40, REGW=8'h80, REGR=8'hC0, TX_ERR_BYTE=8'hFF.
//   - rxcmd field localparams: linestate[1:0], vbus[3:2], rxevent[5:4].
//  Sub-module ulpi_tx_fifo (sync FIFO, DEPTH param, stores {last,data}, 9 bits).
//   - Features: flush-to-last input, wrapping pointers with an extra MSB for full/empty.
// TESTING
//  PID 0xC3, bytes 11 22 33 last, nxt high from cycle 2:
//   -> data 0x43 then 11 22 33, stp one cycle after 33 with data 0x00.
//  Reg write addr 0x0A data 0x55, nxt after 2 cycles:
//   -> 0x8A held, then 0x55, stp, reg_ack=1, reg_err=0.
//  Reg read addr 0x16, PHY raises dir after nxt and returns 0x9C:
//   -> data_oe=0 in turnaround, reg_rdata=0x9C with reg_ack.
//  dir rises mid-packet after 2 bytes:
//   -> tx_abort pulse, FIFO flushed through last, rxcmd 0x4D captured with nxt=0.
//  Payload stalls while nxt=1 with FIFO empty:
//   -> stp=1 with data 0xFF, tx_abort; with nxt held low, REG_TIMEOUT=8 gives reg_err on cycle 8.
//  rst asserted mid TX_DATA:
//   -> next cycle stp=0, data_oe=0, FIFO empty, tx_ready=1 the cycle after.

Source files
------------

// File: rtl/ulpi_pkg.sv
// ============================================================================
//  Module   : ulpi_pkg
//  Purpose  : Shared types and constants for the ULPI link controller:
//             controller state encoding, ULPI command byte prefixes and
//             RX CMD bit-field positions.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ulpi_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TX_CMD   = 4'd1,
    TX_DATA  = 4'd2,
    TX_STP   = 4'd3,
    REG_CMD  = 4'd4,
    REG_WD   = 4'd5,
    REG_STP  = 4'd6,
    REG_TURN = 4'd7,
    REG_RD   = 4'd8
  } state_t;

  // Command byte prefixes (low bits carry PID nibble or register address)
  localparam logic [7:0] TXCMD_NOPID = 8'h40;
  localparam logic [7:0] REGW        = 8'h80;
  localparam logic [7:0] REGR        = 8'hC0;
  localparam logic [7:0] TX_ERR_BYTE = 8'hFF;

  // RX CMD byte field positions
  localparam int RXCMD_LINESTATE_LSB = 0;
  localparam int RXCMD_LINESTATE_MSB = 1;
  localparam int RXCMD_VBUS_LSB      = 2;
  localparam int RXCMD_VBUS_MSB      = 3;
  localparam int RXCMD_RXEVENT_LSB   = 4;
  localparam int RXCMD_RXEVENT_MSB   = 5;

  function automatic logic [1:0] rxcmd_linestate(input logic [7:0] cmd);
    return cmd[RXCMD_LINESTATE_MSB:RXCMD_LINESTATE_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ulpi_tx_fifo.sv
// ============================================================================
//  Module   : ulpi_tx_fifo
//  Purpose  : Synchronous FIFO of {last,data} entries for outgoing packets.
//             A flush request discards entries from the head up to and
//             including the next one flagged last, even if that entry has
//             not been written yet.
//  Ports    : clk/rst   - clock, synchronous active-high reset
//             push/din  - write strobe and {last,data} entry (ignored if full)
//             pop       - consume head entry
//             flush     - start discarding through the next last entry
//             dout      - head entry; empty/full status; flushing busy flag
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ulpi_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [8:0] din,
  input  logic       pop,
  input  logic       flush,
  output logic [8:0] dout,
  output logic       empty,
  output logic       full,
  output logic       flushing
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        flush_q;
  logic        do_pop;
  logic        do_push;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal)
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout     = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = (pop || flush_q) && !empty;
  assign flushing = flush_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      flush_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (flush) begin
        flush_q <= 1'b1;
      end else if (flush_q && do_pop && dout[8]) begin
        flush_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ulpi_link_ctrl.sv
// ============================================================================
//  Module   : ulpi_link_ctrl
//  Purpose  : Link-side ULPI controller. Owns bus turnaround, sends packets
//             as TX CMD + payload from a byte FIFO, performs PHY register
//             writes/reads, and splits PHY-driven cycles into RX data and
//             RX CMD bytes.
//  Ports    : clk, rst                         - 60 MHz ULPI clock, sync reset
//             ulpi_dir/nxt/stp/data_i/o/oe     - ULPI pad side
//             tx_data/valid/last/ready, tx_abort - packet input stream
//             rx_data/valid/end, rxcmd/_valid  - receive side
//             reg_req/we/addr/wdata/ack/err/rdata - PHY register access
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ulpi_link_ctrl
  import ulpi_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 4,
  parameter int REG_TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_abort,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_end,
  output logic [7:0] rxcmd,
  output logic       rxcmd_valid,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic       reg_err,
  output logic [7:0] reg_rdata
);

  localparam int CW = $clog2(REG_TIMEOUT + 1);

  state_t        state;
  state_t        state_nx;
  logic          dir_q;
  logic          run;
  logic          owned;
  logic          rx_cycle;
  logic          rx_got;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          tmo_run;
  logic          abort_set;
  logic          ack_set;
  logic          err_set;
  logic          rd_latch;

  logic [8:0]    f_dout;
  logic          f_empty;
  logic          f_full;
  logic          f_flushing;
  logic          f_pop;
  logic          f_flush;

  // dir_q resets high so the first cycle after reset is treated as a
  // turnaround and the pads stay released.
  assign owned        = !ulpi_dir && !dir_q;
  assign ulpi_data_oe = owned;
  assign tx_ready     = run && !f_full;
  assign tmo_hit      = (tmo_cnt == CW'(REG_TIMEOUT - 1));

  // A register-read data cycle looks like an RX CMD (dir, no nxt) and
  // must not be reported as one.
  assign rx_cycle = ulpi_dir && dir_q && !((state == REG_RD) && !ulpi_nxt);

  ulpi_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_valid && tx_ready),
    .din      ({tx_last, tx_data}),
    .pop      (f_pop),
    .flush    (f_flush),
    .dout     (f_dout),
    .empty    (f_empty),
    .full     (f_full),
    .flushing (f_flushing)
  );

  always_comb begin
    state_nx    = state;
    ulpi_data_o = 8'h00;
    ulpi_stp    = 1'b0;
    f_pop       = 1'b0;
    f_flush     = 1'b0;
    abort_set   = 1'b0;
    ack_set     = 1'b0;
    err_set     = 1'b0;
    rd_latch    = 1'b0;
    tmo_run     = 1'b0;
    case (state)
      IDLE: begin
        // reg_ack is still high the cycle the requester drops reg_req;
        // blocking on it prevents a spurious repeat of the same access.
        if (owned) begin
          if (reg_req && !reg_ack) begin
            state_nx = REG_CMD;
          end else if (!f_empty && !f_flushing) begin
            state_nx = TX_CMD;
          end
        end
      end
      TX_CMD: begin
        ulpi_data_o = TXCMD_NOPID | {4'h0, f_dout[3:0]};
        if (ulpi_dir) begin
          abort_set = 1'b1;
          f_flush   = 1'b1;
          state_nx  = IDLE;
        end else if (ulpi_nxt) begin
          f_pop    = 1'b1;
          state_nx = f_dout[8] ? TX_STP : TX_DATA;
        end
      end
      TX_DATA: begin
        if (ulpi_dir) begin
          abort_set = 1'b1;
          f_flush   = 1'b1;
          state_nx  = IDLE;
        end else if (f_empty) begin
          ulpi_data_o = TX_ERR_BYTE;
          if (ulpi_nxt) begin
            ulpi_stp  = 1'b1;
            abort_set = 1'b1;
            f_flush   = 1'b1;
            state_nx  = IDLE;
          end
        end else begin
          ulpi_data_o = f_dout[7:0];
          if (ulpi_nxt) begin
            f_pop = 1'b1;
            if (f_dout[8]) begin
              state_nx = TX_STP;
            end
          end
        end
      end
      TX_STP: begin
        ulpi_stp = 1'b1;
        state_nx = IDLE;
      end
      REG_CMD: begin
        ulpi_data_o = (reg_we ? REGW : REGR) | {2'b00, reg_addr};
        if (ulpi_dir) begin
          state_nx = IDLE;
        end else if (ulpi_nxt) begin
          state_nx = reg_we ? REG_WD : REG_TURN;
        end else if (tmo_hit) begin
          ack_set  = 1'b1;
          err_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_run = 1'b1;
        end
      end
      REG_WD: begin
        ulpi_data_o = reg_wdata;
        if (ulpi_dir) begin
          state_nx = IDLE;
        end else if (ulpi_nxt) begin
          state_nx = REG_STP;
        end else if (tmo_hit) begin
          ack_set  = 1'b1;
          err_set  = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_run = 1'b1;
        end
      end
      REG_STP: begin
        ulpi_stp = 1'b1;
        ack_set  = 1'b1;
        state_nx = IDLE;
      end
      REG_TURN: begin
        state_nx = ulpi_dir ? REG_RD : IDLE;
      end
      REG_RD: begin
        // Anything but a clean data cycle drops the op; reg_req stays
        // pending and the access restarts from IDLE.
        if (ulpi_dir && dir_q && !ulpi_nxt) begin
          rd_latch = 1'b1;
          ack_set  = 1'b1;
        end
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dir_q       <= 1'b1;
      run         <= 1'b0;
      tmo_cnt     <= '0;
      tx_abort    <= 1'b0;
      reg_ack     <= 1'b0;
      reg_err     <= 1'b0;
      reg_rdata   <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_end      <= 1'b0;
      rx_got      <= 1'b0;
      rxcmd       <= 8'h00;
      rxcmd_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      dir_q       <= ulpi_dir;
      run         <= 1'b1;
      tmo_cnt     <= tmo_run ? tmo_cnt + 1'b1 : '0;
      tx_abort    <= abort_set;
      reg_ack     <= ack_set;
      reg_err     <= err_set;
      rx_valid    <= 1'b0;
      rxcmd_valid <= 1'b0;
      rx_end      <= 1'b0;
      if (rd_latch) begin
        reg_rdata <= ulpi_data_i;
      end
      if (rx_cycle) begin
        if (ulpi_nxt) begin
          rx_data  <= ulpi_data_i;
          rx_valid <= 1'b1;
          rx_got   <= 1'b1;
        end else begin
          rxcmd       <= ulpi_data_i;
          rxcmd_valid <= 1'b1;
        end
      end
      if (dir_q && !ulpi_dir) begin
        rx_end <= rx_got;
        rx_got <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
